// File: rtl/rv_data_mem_ctrl.sv
// rv_data_mem_ctrl: RV32I data memory with byte lanes, sign/zero
// extended loads, configurable wait states and error reporting.
module rv_data_mem_ctrl #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 1024,
   parameter int ADD_SIZE    = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_req,
   input  logic                i_we,
   input  logic [1:0]          i_size,
   input  logic                i_unsigned,
   input  logic [ADD_SIZE-1:0] i_add,
   input  logic [WIDTH-1:0]    i_wdata,
   output logic                o_ready,
   output logic                o_done,
   output logic [WIDTH-1:0]    o_rdata,
   output logic                o_err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (WIDTH != 32) begin : g_width_chk
      $error("rv_data_mem_ctrl: WIDTH must be 32");
   end
   if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_ws_chk
      $error("rv_data_mem_ctrl: WAIT_STATES must be 0..7");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t state, state_nx;
   logic [2:0] cnt, cnt_nx;

   logic                accept;
   logic                commit;
   logic                we_q, uns_q;
   logic [1:0]          size_q;
   logic [ADD_SIZE-1:0] add_q;
   logic [WIDTH-1:0]    wdata_q;

   logic                op_we, op_uns;
   logic [1:0]          op_size;
   logic [ADD_SIZE-1:0] op_add;
   logic [WIDTH-1:0]    op_wdata;
   logic                op_err;
   logic                mis_err, rng_err;

   logic [IW-1:0]       idx;
   logic [3:0]          be;
   logic [WIDTH-1:0]    wd_lane;
   logic [WIDTH-1:0]    word_rd;
   logic [7:0]          byte_v;
   logic [15:0]         half_v;
   logic [WIDTH-1:0]    ld_data;

   logic                err_q;
   logic [WIDTH-1:0]    rdata_q;
   logic [WIDTH-1:0]    mem [DEPTH];

   assign o_ready = (state == S_IDLE) || (state == S_RESP);
   assign accept  = i_req && o_ready;
   assign o_done  = (state == S_RESP);
   assign o_err   = o_done && err_q;
   assign o_rdata = o_done ? rdata_q : '0;

   // Every entry into RESP performs the access, so that edge is the commit.
   assign commit = (state_nx == S_RESP);

   // State register and wait counter.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= S_IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state: accept from IDLE/RESP, count down in WAIT.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         S_IDLE, S_RESP: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_nx = S_RESP;
               end else begin
                  state_nx = S_WAIT;
                  cnt_nx   = 3'(WAIT_STATES);
               end
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_WAIT: begin
            cnt_nx = cnt - 3'd1;
            if (cnt == 3'd1) state_nx = S_RESP;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Capture request fields at the accepting edge.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         add_q   <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= i_we;
         uns_q   <= i_unsigned;
         size_q  <= i_size;
         add_q   <= i_add;
         wdata_q <= i_wdata;
      end
   end

   // Zero wait states commit on the accepting edge itself, so the
   // live inputs are used; otherwise the latched copy from WAIT.
   always_comb begin
      op_we    = i_we;
      op_uns   = i_unsigned;
      op_size  = i_size;
      op_add   = i_add;
      op_wdata = i_wdata;
      if (state == S_WAIT) begin
         op_we    = we_q;
         op_uns   = uns_q;
         op_size  = size_q;
         op_add   = add_q;
         op_wdata = wdata_q;
      end
   end

   // Alignment and range checks on the operation being committed.
   always_comb begin
      mis_err = 1'b0;
      unique case (op_size)
         2'b00:   mis_err = 1'b0;
         2'b01:   mis_err = op_add[0];
         2'b10:   mis_err = |op_add[1:0];
         default: mis_err = 1'b1;
      endcase
      rng_err = {2'b00, op_add[ADD_SIZE-1:2]} >= ADD_SIZE'(DEPTH);
      op_err  = mis_err || rng_err;
   end

   assign idx = op_add[IW+1:2];

   // Byte-lane enables and lane-replicated store data.
   always_comb begin
      be      = 4'b1111;
      wd_lane = op_wdata;
      unique case (op_size)
         2'b00: begin
            be      = 4'b0001 << op_add[1:0];
            wd_lane = {4{op_wdata[7:0]}};
         end
         2'b01: begin
            be      = op_add[1] ? 4'b1100 : 4'b0011;
            wd_lane = {2{op_wdata[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            wd_lane = op_wdata;
         end
      endcase
   end

   // Load extraction with sign or zero extension.
   always_comb begin
      word_rd = mem[idx];
      byte_v  = word_rd[8*op_add[1:0] +: 8];
      half_v  = op_add[1] ? word_rd[31:16] : word_rd[15:0];
      ld_data = word_rd;
      unique case (op_size)
         2'b00:
            ld_data = op_uns ? {24'd0, byte_v}
                             : {{24{byte_v[7]}}, byte_v};
         2'b01:
            ld_data = op_uns ? {16'd0, half_v}
                             : {{16{half_v[15]}}, half_v};
         default: ld_data = word_rd;
      endcase
   end

   // Data array: cleared on reset, lane writes on a clean store commit.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (commit && op_we && !op_err) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) mem[idx][8*l +: 8] <= wd_lane[8*l +: 8];
         end
      end
   end

   // Response registers, loaded on the edge that enters RESP.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else if (commit) begin
         err_q   <= op_err;
         rdata_q <= (op_err || op_we) ? '0 : ld_data;
      end
   end

endmodule

// File: tb/tb_rv_data_mem_ctrl.sv
// tb_rv_data_mem_ctrl: three instances (0, 2, 3 wait states) checked
// against a byte-array reference model with cycle-accurate timing.
module tb_rv_data_mem_ctrl;

   localparam int DEPTH = 64;
   localparam int NB    = DEPTH * 4;

   typedef struct {
      bit        we;
      bit [1:0]  size;
      bit        uns;
      bit [31:0] add;
      bit [31:0] wdata;
   } op_t;

   typedef struct {
      int        cyc;
      bit        err;
      bit [31:0] rd;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic [2:0]  req;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] add;
   logic [31:0] wdata;
   logic [2:0]  rdy, dn, er;
   logic [31:0] rd [3];

   int          ws [3] = '{0, 2, 3};
   logic [7:0]  mem_m [3][NB];
   op_t         ops_q [$];
   bit          gaps_en;
   int          nchk;
   int          nbad;

   rv_data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
      .i_clk(clk), .i_rstn(rstn), .i_req(req[0]), .i_we(we),
      .i_size(size), .i_unsigned(uns), .i_add(add),
      .i_wdata(wdata), .o_ready(rdy[0]), .o_done(dn[0]),
      .o_rdata(rd[0]), .o_err(er[0]));

   rv_data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(2)) u2 (
      .i_clk(clk), .i_rstn(rstn), .i_req(req[1]), .i_we(we),
      .i_size(size), .i_unsigned(uns), .i_add(add),
      .i_wdata(wdata), .o_ready(rdy[1]), .o_done(dn[1]),
      .o_rdata(rd[1]), .o_err(er[1]));

   rv_data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(3)) u3 (
      .i_clk(clk), .i_rstn(rstn), .i_req(req[2]), .i_we(we),
      .i_size(size), .i_unsigned(uns), .i_add(add),
      .i_wdata(wdata), .o_ready(rdy[2]), .o_done(dn[2]),
      .o_rdata(rd[2]), .o_err(er[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_clear();
      for (int k = 0; k < 3; k++)
         for (int b = 0; b < NB; b++) mem_m[k][b] = 8'h00;
   endfunction

   function automatic void push(bit w, bit [1:0] s, bit u,
                                bit [31:0] a, bit [31:0] d);
      op_t o;
      o.we = w; o.size = s; o.uns = u; o.add = a; o.wdata = d;
      ops_q.push_back(o);
   endfunction

   task automatic model_exec(int k, op_t o,
                             output bit e, output bit [31:0] r);
      int n;
      e = (o.size == 2'b11) ||
          (o.size == 2'b01 && o.add[0]) ||
          (o.size == 2'b10 && o.add[1:0] != 2'b00) ||
          ((o.add >> 2) >= DEPTH);
      r = 32'd0;
      if (e) return;
      n = 1 << o.size;
      if (o.we) begin
         for (int i = 0; i < n; i++)
            mem_m[k][o.add + i] = o.wdata[8*i +: 8];
      end else begin
         for (int i = 0; i < n; i++)
            r[8*i +: 8] = mem_m[k][o.add + i];
         if (!o.uns && n < 4 && r[8*n-1])
            for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
      end
   endtask

   task automatic drive_idle();
      we    = 1'($urandom);
      size  = 2'($urandom);
      uns   = 1'($urandom);
      add   = $urandom;
      wdata = $urandom;
   endtask

   // Issues ops_q on instance k, checking every cycle at negedge.
   task automatic run_ops(int k);
      int   cyc = 0;
      int   last_done = -1;
      exp_t eq [$];
      exp_t x;
      op_t  o;
      bit   rdy_e, done_e, e;
      bit [31:0] r;
      while ((ops_q.size() > 0 || eq.size() > 0) && cyc < 4000) begin
         @(negedge clk);
         rdy_e  = (cyc >= last_done);
         done_e = (eq.size() > 0) && (eq[0].cyc == cyc);
         nchk++;
         if (rdy[k] !== rdy_e) begin
            nbad++;
            $display("FAIL ready k=%0d cyc=%0d got=%b exp=%b",
                     k, cyc, rdy[k], rdy_e);
         end
         nchk++;
         if (dn[k] !== done_e) begin
            nbad++;
            $display("FAIL done k=%0d cyc=%0d got=%b exp=%b",
                     k, cyc, dn[k], done_e);
         end
         if (done_e) begin
            x = eq.pop_front();
            nchk++;
            if (er[k] !== x.err) begin
               nbad++;
               $display("FAIL err k=%0d cyc=%0d got=%b exp=%b",
                        k, cyc, er[k], x.err);
            end
            nchk++;
            if (rd[k] !== x.rd) begin
               nbad++;
               $display("FAIL rdata k=%0d cyc=%0d got=%h exp=%h",
                        k, cyc, rd[k], x.rd);
            end
         end else begin
            nchk++;
            if (rd[k] !== 32'd0 || er[k] !== 1'b0) begin
               nbad++;
               $display("FAIL idle_out k=%0d cyc=%0d got=%h/%b exp=0/0",
                        k, cyc, rd[k], er[k]);
            end
         end
         if (ops_q.size() > 0 && rdy_e &&
             !(gaps_en && $urandom_range(0, 3) == 0)) begin
            o = ops_q.pop_front();
            we = o.we; size = o.size; uns = o.uns;
            add = o.add; wdata = o.wdata;
            req[k] = 1'b1;
            model_exec(k, o, e, r);
            x.cyc = cyc + 1 + ws[k];
            x.err = e;
            x.rd  = r;
            eq.push_back(x);
            last_done = x.cyc;
         end else begin
            req[k] = 1'b0;
            drive_idle();
         end
         cyc++;
      end
      req[k] = 1'b0;
      if (cyc >= 4000) begin
         nbad++;
         $display("FAIL run_timeout k=%0d got=%0d exp=<4000", k, cyc);
         ops_q.delete();
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req  = 3'b000;
      drive_idle();
      model_clear();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         nchk++;
         if (rdy[k] !== 1'b1 || dn[k] !== 1'b0 ||
             er[k] !== 1'b0 || rd[k] !== 32'd0) begin
            nbad++;
            $display("FAIL reset k=%0d got=%b%b%b/%h exp=100/0",
                     k, rdy[k], dn[k], er[k], rd[k]);
         end
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word_ws2();
      push(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
      push(0, 2'b10, 0, 32'h10, 32'h0);
      run_ops(1);
      push(0, 2'b10, 0, 32'h10, 32'h0);
      run_ops(1);
   endtask

   task automatic test_lanes();
      push(1, 2'b10, 0, 32'h20, 32'h0);
      push(1, 2'b00, 0, 32'h23, 32'h80);
      push(0, 2'b00, 0, 32'h23, 32'h0);
      push(0, 2'b00, 1, 32'h23, 32'h0);
      push(0, 2'b10, 0, 32'h20, 32'h0);
      run_ops(0);
   endtask

   task automatic test_half();
      push(1, 2'b01, 0, 32'h42, 32'h8001);
      push(0, 2'b01, 0, 32'h42, 32'h0);
      push(0, 2'b01, 1, 32'h42, 32'h0);
      push(0, 2'b10, 0, 32'h40, 32'h0);
      run_ops(0);
   endtask

   task automatic test_errors();
      push(1, 2'b10, 0, 32'h30, 32'hA5A5A5A5);
      push(0, 2'b10, 0, 32'h22, 32'h0);
      push(1, 2'b01, 0, 32'h31, 32'h1234);
      push(1, 2'b11, 0, 32'h30, 32'hFFFFFFFF);
      push(0, 2'b10, 0, NB, 32'h0);
      push(1, 2'b10, 0, NB, 32'h5A5A5A5A);
      push(0, 2'b10, 0, 32'h30, 32'h0);
      push(0, 2'b10, 0, 32'h00, 32'h0);
      run_ops(0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      we = 1'b1; size = 2'b10; uns = 1'b0;
      add = 32'h50; wdata = 32'h12345678;
      req[2] = 1'b1;
      @(negedge clk);
      req[2] = 1'b0;
      drive_idle();
      nchk++;
      if (rdy[2] !== 1'b0) begin
         nbad++;
         $display("FAIL mid_busy got=%b exp=0", rdy[2]);
      end
      rstn = 1'b0;
      #1;
      nchk++;
      if (rdy[2] !== 1'b1 || dn[2] !== 1'b0 ||
          er[2] !== 1'b0 || rd[2] !== 32'd0) begin
         nbad++;
         $display("FAIL mid_reset got=%b%b%b/%h exp=100/0",
                  rdy[2], dn[2], er[2], rd[2]);
      end
      model_clear();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      push(0, 2'b10, 0, 32'h50, 32'h0);
      run_ops(2);
      push(0, 2'b10, 0, 32'h10, 32'h0);
      run_ops(1);
   endtask

   task automatic test_idle();
      req = 3'b000;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         drive_idle();
         for (int k = 0; k < 3; k++) begin
            nchk++;
            if (dn[k] !== 1'b0 || rdy[k] !== 1'b1) begin
               nbad++;
               $display("FAIL idle k=%0d c=%0d got=%b%b exp=01",
                        k, c, dn[k], rdy[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      bit [1:0]  s;
      bit [31:0] a;
      gaps_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 80; n++) begin
            s = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, NB - 1));
            if ($urandom_range(0, 3) != 0 && s != 2'b11)
               a = a & ~((32'd1 << s) - 32'd1);
            if ($urandom_range(0, 15) == 0)
               a = 32'(NB) + 32'($urandom_range(0, 63));
            a = a & 32'h3C | (a & ~32'h3C & 32'hFFFF_FFC3);
            push(1'($urandom), s, 1'($urandom), a, $urandom);
         end
         run_ops(k);
      end
      gaps_en = 1'b0;
   endtask

   initial begin
      nchk    = 0;
      nbad    = 0;
      gaps_en = 1'b0;
      test_reset();
      test_word_ws2();
      test_lanes();
      test_half();
      test_errors();
      test_reset_mid();
      test_idle();
      test_random();
      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule
